// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency synchronous memory between the
//   instruction-fetch port and the load/store data port. It runs one access at
//   a time as IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE. Data has priority.
//   A run counter stops a continuous stream of data accesses from starving a
//   pending fetch.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   inst_req/inst_addr            fetch request (level, held until inst_valid)
//   inst_rdata/inst_valid         fetched word and its one-cycle completion pulse
//   inst_stall                    inst_req & ~inst_valid
//   data_req/data_wen/data_addr/data_wdata
//                                 load/store request (wen==0 means load)
//   data_rdata/data_valid         load word and its one-cycle completion pulse
//   data_stall                    data_req & ~data_valid
//   mem_en/mem_wen/mem_addr/mem_wdata
//                                 memory command, mem_en high one cycle per access
//   mem_rdata                     memory read data, valid MEM_LAT cycles after mem_en
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_valid,
  output logic        inst_stall,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        data_stall,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned  RUN_W    = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);
  localparam logic [1:0]   LAT_INIT = 2'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  state_t           state;
  state_t           state_nxt;
  owner_t           owner;
  logic [1:0]       lat_cnt;
  logic [RUN_W-1:0] run;
  logic             grant_data;
  logic             grant_inst;

  // Arbitration is only evaluated in IDLE, so the port completing in DONE
  // (whose req is still high) cannot be granted a second time.
  always_comb begin
    grant_data = (state == IDLE) && data_req && (!inst_req || (run < RUN_MAX));
    grant_inst = (state == IDLE) && inst_req && !grant_data;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_data || grant_inst) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == 2'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; the strobe and valid pulses are one state long.
  always_comb begin
    mem_en     = (state == ISSUE);
    inst_valid = (state == DONE) && (owner == OWN_INST);
    data_valid = (state == DONE) && (owner == OWN_DATA);
    inst_stall = inst_req & ~inst_valid;
    data_stall = data_req & ~data_valid;
  end

  // Command, latency counter, run counter and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_INST;
      mem_wen    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lat_cnt    <= '0;
      run        <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            owner     <= OWN_DATA;
            mem_addr  <= data_addr;
            mem_wen   <= data_wen;
            mem_wdata <= data_wdata;
            if (!inst_req)           run <= '0;
            else if (run != RUN_MAX) run <= run + 1'b1;
          end else if (grant_inst) begin
            owner     <= OWN_INST;
            mem_addr  <= inst_addr;
            mem_wen   <= '0;
            mem_wdata <= data_wdata;
            run       <= '0;
          end
        end
        ISSUE: begin
          mem_wen <= '0;
          lat_cnt <= LAT_INIT;
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            if (owner == OWN_DATA) data_rdata <= mem_rdata;
            else                   inst_rdata <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: instance A (MEM_LAT=1) and instance B
// (MEM_LAT=3), each with its own behavioural memory.
module tb_mem_port_arbiter;

  localparam int unsigned LAT_A  = 1;
  localparam int unsigned LAT_B  = 3;
  localparam int unsigned MAXRUN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_inst_req, a_inst_valid, a_inst_stall, a_data_req, a_data_valid, a_data_stall, a_mem_en;
  logic [31:0] a_inst_addr, a_inst_rdata, a_data_addr, a_data_wdata, a_data_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_data_wen, a_mem_wen;
  logic        b_inst_req, b_inst_valid, b_inst_stall, b_data_req, b_data_valid, b_data_stall, b_mem_en;
  logic [31:0] b_inst_addr, b_inst_rdata, b_data_addr, b_data_wdata, b_data_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_data_wen, b_mem_wen;

  int checks = 0;
  int passes = 0;

  mem_port_arbiter #(.MEM_LAT(LAT_A), .MAX_DATA_RUN(MAXRUN)) u_dut_a (
    .clk(clk), .rst(rst),
    .inst_req(a_inst_req), .inst_addr(a_inst_addr), .inst_rdata(a_inst_rdata),
    .inst_valid(a_inst_valid), .inst_stall(a_inst_stall),
    .data_req(a_data_req), .data_wen(a_data_wen), .data_addr(a_data_addr),
    .data_wdata(a_data_wdata), .data_rdata(a_data_rdata), .data_valid(a_data_valid),
    .data_stall(a_data_stall), .mem_en(a_mem_en), .mem_wen(a_mem_wen),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(LAT_B), .MAX_DATA_RUN(MAXRUN)) u_dut_b (
    .clk(clk), .rst(rst),
    .inst_req(b_inst_req), .inst_addr(b_inst_addr), .inst_rdata(b_inst_rdata),
    .inst_valid(b_inst_valid), .inst_stall(b_inst_stall),
    .data_req(b_data_req), .data_wen(b_data_wen), .data_addr(b_data_addr),
    .data_wdata(b_data_wdata), .data_rdata(b_data_rdata), .data_valid(b_data_valid),
    .data_stall(b_data_stall), .mem_en(b_mem_en), .mem_wen(b_mem_wen),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Behavioural memories: the word is read at the mem_en edge and presented
  // only in cycle mem_en+LAT. Other cycles carry random junk.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] ref_a [256];
  logic [31:0] pd_a, pd_b;
  int cnt_a = 0;
  int cnt_b = 0;

  always @(posedge clk) begin
    if (a_mem_en) begin
      pd_a = mem_a[a_mem_addr[9:2]];
      for (int i = 0; i < 4; i++)
        if (a_mem_wen[i]) mem_a[a_mem_addr[9:2]][8*i +: 8] = a_mem_wdata[8*i +: 8];
      cnt_a = LAT_A;
    end
    a_mem_rdata <= (cnt_a == 1) ? pd_a : $urandom;
    if (cnt_a > 0) cnt_a = cnt_a - 1;
  end

  always @(posedge clk) begin
    if (b_mem_en) begin
      pd_b = mem_b[b_mem_addr[9:2]];
      for (int i = 0; i < 4; i++)
        if (b_mem_wen[i]) mem_b[b_mem_addr[9:2]][8*i +: 8] = b_mem_wdata[8*i +: 8];
      cnt_b = LAT_B;
    end
    b_mem_rdata <= (cnt_b == 1) ? pd_b : $urandom;
    if (cnt_b > 0) cnt_b = cnt_b - 1;
  end

  task automatic clear_inputs;
    a_inst_req = 0; a_inst_addr = '0; a_data_req = 0; a_data_wen = '0; a_data_addr = '0; a_data_wdata = '0;
    b_inst_req = 0; b_inst_addr = '0; b_data_req = 0; b_data_wen = '0; b_data_addr = '0; b_data_wdata = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({a_mem_en, a_mem_wen, a_mem_addr, a_mem_wdata} !== '0) $display("FAIL reset_mem_a: got %h want 0", {a_mem_en, a_mem_wen, a_mem_addr, a_mem_wdata});
    else passes++;
    checks++;
    if ({a_inst_valid, a_data_valid, a_inst_rdata, a_data_rdata} !== '0) $display("FAIL reset_port_a: got %h want 0", {a_inst_valid, a_data_valid, a_inst_rdata, a_data_rdata});
    else passes++;
    checks++;
    if ({b_mem_en, b_mem_wen, b_mem_addr, b_inst_valid, b_data_valid, b_inst_rdata, b_data_rdata} !== '0)
      $display("FAIL reset_b: got %h want 0", {b_mem_en, b_mem_wen, b_mem_addr, b_inst_valid, b_data_valid, b_inst_rdata, b_data_rdata});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_fetch;
    do_reset();
    mem_a[4] = 32'h8C080004;
    @(negedge clk);
    a_inst_req = 1; a_inst_addr = 32'h10;
    #1;
    checks++;
    if (a_inst_stall !== 1'b1) $display("FAIL fetch_stall_c: got %b want 1", a_inst_stall); else passes++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (!(a_mem_en === 1'b1 && a_mem_addr === 32'h10 && a_mem_wen === 4'b0))
          $display("FAIL fetch_issue: got en=%b addr=%h wen=%h want en=1 addr=10 wen=0", a_mem_en, a_mem_addr, a_mem_wen);
        else passes++;
      end
      if (k == 2) begin
        checks++;
        if (!(a_mem_en === 1'b0 && a_inst_valid === 1'b0 && a_inst_stall === 1'b1))
          $display("FAIL fetch_wait: got en=%b valid=%b stall=%b want 0 0 1", a_mem_en, a_inst_valid, a_inst_stall);
        else passes++;
      end
      if (k == 3) begin
        checks++;
        if (!(a_inst_valid === 1'b1 && a_inst_rdata === 32'h8C080004 && a_inst_stall === 1'b0 && a_data_valid === 1'b0))
          $display("FAIL fetch_done: got valid=%b rdata=%h stall=%b dvalid=%b want 1 8c080004 0 0", a_inst_valid, a_inst_rdata, a_inst_stall, a_data_valid);
        else passes++;
        a_inst_req = 0;
      end
      if (k == 4) begin
        checks++;
        if (!(a_inst_valid === 1'b0 && a_inst_rdata === 32'h8C080004 && a_mem_en === 1'b0))
          $display("FAIL fetch_hold: got valid=%b rdata=%h en=%b want 0 8c080004 0", a_inst_valid, a_inst_rdata, a_mem_en);
        else passes++;
      end
    end
  endtask

  task automatic test_store;
    int ne, dv, iv;
    ne = 0; dv = 0; iv = 0;
    do_reset();
    @(negedge clk);
    a_data_req = 1; a_data_wen = 4'b0011; a_data_addr = 32'h100; a_data_wdata = 32'h0000BEEF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (a_mem_en) begin
        ne++;
        checks++;
        if (!(a_mem_wen === 4'b0011 && a_mem_addr === 32'h100 && a_mem_wdata === 32'h0000BEEF))
          $display("FAIL store_cmd: got wen=%h addr=%h wdata=%h want 3 100 0000beef", a_mem_wen, a_mem_addr, a_mem_wdata);
        else passes++;
      end
      if (a_inst_valid) iv++;
      if (a_data_valid) begin
        dv++;
        checks++;
        if (k != 3) $display("FAIL store_latency: got cycle %0d want 3", k); else passes++;
        a_data_req = 0; a_data_wen = '0;
      end
    end
    checks++;
    if (!(ne == 1 && dv == 1 && iv == 0)) $display("FAIL store_counts: got en=%0d dvalid=%0d ivalid=%0d want 1 1 0", ne, dv, iv);
    else passes++;
  endtask

  task automatic test_contention;
    int g;
    logic is_data;
    g = 0;
    do_reset();
    @(negedge clk);
    a_inst_req = 1; a_inst_addr = 32'h40;
    a_data_req = 1; a_data_addr = 32'h80; a_data_wen = '0;
    for (int cyc = 0; cyc < 60 && g < 10; cyc++) begin
      @(negedge clk);
      if (a_mem_en) begin
        is_data = (a_mem_addr == 32'h80);
        checks++;
        if (is_data !== ((g % 5) != 4)) $display("FAIL contention_grant%0d: got data=%b want data=%b", g, is_data, (g % 5) != 4);
        else passes++;
        g++;
      end
    end
    checks++;
    if (g != 10) $display("FAIL contention_timeout: got %0d grants want 10", g); else passes++;
    a_inst_req = 0; a_data_req = 0;
  endtask

  task automatic test_lat3_load;
    int ne;
    ne = 0;
    do_reset();
    mem_b[128] = 32'h12345678;
    @(negedge clk);
    b_data_req = 1; b_data_addr = 32'h200; b_data_wen = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (b_mem_en) begin
        ne++;
        checks++;
        if (!(k == 1 && b_mem_addr === 32'h200 && b_mem_wen === 4'b0))
          $display("FAIL lat3_issue: got cycle=%0d addr=%h wen=%h want 1 200 0", k, b_mem_addr, b_mem_wen);
        else passes++;
      end
      checks++;
      if (b_data_valid !== (k == 5) || b_data_stall !== (k < 5))
        $display("FAIL lat3_valid_c%0d: got valid=%b stall=%b want %b %b", k, b_data_valid, b_data_stall, k == 5, k < 5);
      else passes++;
      if (k == 5) begin
        checks++;
        if (b_data_rdata !== 32'h12345678) $display("FAIL lat3_rdata: got %h want 12345678", b_data_rdata); else passes++;
        b_data_req = 0;
      end
    end
    checks++;
    if (ne != 1) $display("FAIL lat3_en_count: got %0d want 1", ne); else passes++;
  endtask

  task automatic test_reset_mid;
    bit done;
    done = 0;
    do_reset();
    mem_a[4] = 32'h8C080004;
    mem_a[8] = 32'hCAFE0020;
    @(negedge clk);
    a_inst_req = 1; a_inst_addr = 32'h10;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (a_inst_valid) begin done = 1; a_inst_req = 0; end
    end
    checks++;
    if (!done || a_inst_rdata !== 32'h8C080004) $display("FAIL rstmid_prefetch: got done=%b rdata=%h want 1 8c080004", done, a_inst_rdata);
    else passes++;
    @(negedge clk);
    a_inst_req = 1; a_inst_addr = 32'h20;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({a_mem_en, a_mem_wen, a_mem_addr, a_mem_wdata, a_inst_valid, a_data_valid, a_inst_rdata, a_data_rdata} !== '0)
      $display("FAIL rstmid_outputs: got en=%b addr=%h ivalid=%b irdata=%h want all 0", a_mem_en, a_mem_addr, a_inst_valid, a_inst_rdata);
    else passes++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (a_inst_valid !== 1'b0 || a_mem_en !== 1'b0) $display("FAIL rstmid_quiet: got valid=%b en=%b want 0 0", a_inst_valid, a_mem_en);
      else passes++;
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (a_mem_en !== (k == 1) || a_inst_valid !== (k == 3))
        $display("FAIL rstmid_after_c%0d: got en=%b valid=%b want %b %b", k, a_mem_en, a_inst_valid, k == 1, k == 3);
      else passes++;
      if (k == 3) begin
        checks++;
        if (a_inst_rdata !== 32'hCAFE0020) $display("FAIL rstmid_rdata: got %h want cafe0020", a_inst_rdata); else passes++;
        a_inst_req = 0;
      end
    end
  endtask

  task automatic test_no_double_grant;
    int ne, seen;
    ne = 0; seen = 0;
    do_reset();
    @(negedge clk);
    a_inst_req = 1; a_inst_addr = 32'h30;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (a_mem_en) ne++;
      if (a_inst_valid) begin
        seen++;
        @(posedge clk);
        #1 a_inst_req = 0;
      end
    end
    checks++;
    if (ne != 1 || seen != 1) $display("FAIL no_double_grant: got en=%0d valid=%0d want 1 1", ne, seen);
    else passes++;
  endtask

  // Transaction-level reference: one access at a time, data preferred unless
  // MAXRUN data grants have already passed over a waiting fetch. Each valid
  // must arrive LAT+1 cycles after its strobe, loads return the reference image.
  task automatic test_random;
    bit busy, own_data, want_data, ok;
    int since, streak, last_valid;
    logic [31:0] exp_rd;
    logic [7:0] idx;
    busy = 0; own_data = 0; since = 0; streak = 0; last_valid = -10; exp_rd = '0;
    do_reset();
    for (int i = 0; i < 256; i++) ref_a[i] = mem_a[i];
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      checks++;
      if (a_inst_stall !== (a_inst_req & ~a_inst_valid) || a_data_stall !== (a_data_req & ~a_data_valid))
        $display("FAIL rand_stall@%0d: got i=%b d=%b want i=%b d=%b", cyc, a_inst_stall, a_data_stall,
                 a_inst_req & ~a_inst_valid, a_data_req & ~a_data_valid);
      else passes++;
      if (busy) since++;
      if (a_mem_en) begin
        want_data = a_data_req && (!a_inst_req || streak < int'(MAXRUN));
        ok = !busy && (cyc - last_valid >= 2) && (a_inst_req || a_data_req) &&
             (want_data ? (a_mem_addr === a_data_addr && a_mem_wen === a_data_wen && a_mem_wdata === a_data_wdata)
                        : (a_mem_addr === a_inst_addr && a_mem_wen === 4'b0));
        checks++;
        if (!ok) $display("FAIL rand_grant@%0d: got addr=%h wen=%h want %s addr=%h", cyc, a_mem_addr, a_mem_wen,
                          want_data ? "data" : "inst", want_data ? a_data_addr : a_inst_addr);
        else passes++;
        if (want_data && a_inst_req) streak = (streak < int'(MAXRUN)) ? streak + 1 : streak;
        else streak = 0;
        idx = want_data ? a_data_addr[9:2] : a_inst_addr[9:2];
        exp_rd = ref_a[idx];
        if (want_data)
          for (int i = 0; i < 4; i++)
            if (a_data_wen[i]) ref_a[idx][8*i +: 8] = a_data_wdata[8*i +: 8];
        busy = 1; own_data = want_data; since = 0;
      end
      if (a_inst_valid || a_data_valid) begin
        checks++;
        if (!(busy && since == int'(LAT_A) + 1 && (a_data_valid ? (own_data && !a_inst_valid) : !own_data)))
          $display("FAIL rand_valid@%0d: got iv=%b dv=%b after %0d cycles want %s after %0d", cyc, a_inst_valid,
                   a_data_valid, since, own_data ? "data" : "inst", LAT_A + 1);
        else passes++;
        if (a_inst_valid || a_data_wen == 4'b0) begin
          checks++;
          if ((a_inst_valid ? a_inst_rdata : a_data_rdata) !== exp_rd)
            $display("FAIL rand_rdata@%0d: got %h want %h", cyc, a_inst_valid ? a_inst_rdata : a_data_rdata, exp_rd);
          else passes++;
        end
        busy = 0; last_valid = cyc;
      end
      if (busy && since > int'(LAT_A) + 1) begin
        checks++;
        $display("FAIL rand_timeout@%0d: got no valid after %0d cycles want %0d", cyc, since, LAT_A + 1);
        busy = 0;
      end
      if (a_inst_valid) a_inst_req = 0;
      if (a_data_valid) a_data_req = 0;
      if (!a_inst_req && $urandom_range(0, 2) != 0) begin
        a_inst_req = 1;
        a_inst_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!a_data_req && $urandom_range(0, 2) != 0) begin
        a_data_req = 1;
        a_data_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        a_data_wen = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
        a_data_wdata = $urandom;
      end
    end
    a_inst_req = 0; a_data_req = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_lat3_load();
    test_reset_mid();
    test_no_double_grant();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the core's instruction-fetch port and its load/store data port.
- Sits between the datapath's fetch/memory stages and the unified memory.
- Arbitrates requests and sequences each access through a fixed-latency memory.
- Returns read data with a one-cycle valid pulse, and drives per-port stall signals that freeze the pipeline while an access is outstanding.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from mem_en high to mem_rdata valid; legal range 1..4.
- MAX_DATA_RUN, 4, maximum consecutive data grants while inst_req is pending before instruction fetch is forced through.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- inst_req  input  1  fetch request; level, held until inst_valid.
- inst_addr  input  32  fetch byte address; stable while inst_req is high.
- inst_rdata  output  32  fetched instruction; meaningful when inst_valid is high.
- inst_valid  output  1  one-cycle completion pulse for fetch.
- inst_stall  output  1  inst_req & ~inst_valid (combinational).
- data_req  input  1  load/store request; level, held until data_valid.
- data_wen  input  4  byte write enables; 0 means read.
- data_addr  input  32  data byte address.
- data_wdata  input  32  store data.
- data_rdata  output  32  load data; meaningful when data_valid is high.
- data_valid  output  1  one-cycle completion pulse for data.
- data_stall  output  1  data_req & ~data_valid (combinational).
- mem_en  output  1  memory access strobe; high for exactly one cycle per access.
- mem_wen  output  4  byte write enables to memory.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data, valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Reset values (async, immediate on rst high):
  - state=IDLE, mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - inst_valid=0, data_valid=0, inst_rdata=0, data_rdata=0.
  - run counter=0, owner=INST.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, arbitration each cycle:
  - If data_req=1 and (inst_req=0 or run<MAX_DATA_RUN): grant DATA.
  - Else if inst_req=1: grant INST.
  - On a grant, register owner, mem_addr, mem_wen (DATA: data_wen; INST: 0) and mem_wdata; set mem_en=1; go to ISSUE.
  - No request: stay in IDLE, mem_en=0.
- Run counter:
  - Increments on a DATA grant while inst_req=1, saturating at MAX_DATA_RUN.
  - Clears on any INST grant, or on any DATA grant with inst_req=0.
- ISSUE:
  - mem_en is high during this cycle only; cleared at the next edge.
  - mem_wen is cleared to 0 at the same edge.
  - Next state: WAIT, counter=MEM_LAT-1; if MEM_LAT=1, go straight to capture.
- WAIT:
  - Counts down.
  - In cycle ISSUE+MEM_LAT, mem_rdata is captured into the owner's rdata register; go to DONE.
- DONE:
  - Owner's valid is high for exactly this cycle; the other port's valid stays 0; return to IDLE.
  - No arbitration happens in DONE.
  - The completing port's req is still high this cycle and must not be re-granted.
  - A new request from that port is accepted from the following IDLE cycle.
- Writes follow the same sequence. The data_valid pulse acknowledges the write; data_rdata is then undefined.
- Latency: request first seen in IDLE cycle C produces mem_en in C+1 and valid in C+2+MEM_LAT. Back-to-back accesses occupy MEM_LAT+3 cycles each.
- rdata registers hold their value after the valid pulse until the next capture for that port.
- Simultaneous requests: DATA wins unless the starvation guard triggers.
- A requester dropping req mid-access is illegal; the access still completes and valid still pulses.
- rst asserted mid-access: the access is abandoned, no valid pulse, FSM returns to IDLE; the memory may have performed a write.
- Only one access is ever outstanding; no pipelining.

Test Plan:
- Single fetch, MEM_LAT=1: inst_req=1, inst_addr=0x00000010, memory returns 0x8C080004 -> mem_en high in C+1 with mem_addr=0x10, mem_wen=0; inst_valid pulses in C+3 with inst_rdata=0x8C080004; inst_stall high C..C+2, low in C+3.
- Store: data_req=1, data_wen=4'b0011, data_addr=0x100, data_wdata=0x0000BEEF -> one mem_en cycle with mem_wen=4'b0011, mem_addr=0x100, mem_wdata=0x0000BEEF; data_valid pulses once; inst_valid stays 0.
- Contention, MAX_DATA_RUN=4: both requests held continuously, data requester re-requests immediately after each valid -> grant order D,D,D,D,I,D,...; the fifth grant is INST.
- MEM_LAT=3 load: data_addr=0x200, memory returns 0x12345678 three cycles after mem_en -> data_valid in C+5 with data_rdata=0x12345678; mem_en high for exactly one cycle.
- Reset mid-access: assert rst during WAIT -> all outputs 0 immediately, no valid pulse; after release, a pending inst_req is granted normally from IDLE.
- No double grant: hold inst_req high through DONE, drop it in the cycle after inst_valid -> exactly one mem_en for that request.
